cordic_seq_ctrl: RTL and testbench

Sequencing controller for the iterative CORDIC datapath. It accepts a start request and drives the operand-mux select, the datapath register enable and the per-iteration shift/arctan-ROM index for a fixed number of micro-rotations. It then presents a valid/ready result handshake to the downstream consumer. It sits between the request source and the CORDIC x/y/z register stage, generalising the one-shot input/feedback mux select into a full start/iterate/done sequencer.

---
 rtl/cordic_pkg.sv | 16 +
 rtl/cordic_iter_counter.sv | 29 ++
 rtl/cordic_seq_ctrl.sv | 78 +++++++
 tb/tb_cordic_seq_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC sequencing controller.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int N_ITER_DEF = 16;

  localparam logic SEL_INPUT    = 1'b0;
  localparam logic SEL_FEEDBACK = 1'b1;

endpackage

// File: rtl/cordic_iter_counter.sv
// Micro-rotation index counter: synchronous clear, count enable, and a
// terminal-count flag at N_ITER-1 where the count saturates (never wraps).
module cordic_iter_counter #(
  parameter int N_ITER = 16,
  parameter int IDX_W  = $clog2(N_ITER)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [IDX_W-1:0] count,
  output logic             tc
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ITER - 1);

  assign tc = (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + IDX_W'(1);
    end
  end

endmodule

// File: rtl/cordic_seq_ctrl.sv
// Start/iterate/done sequencer for the iterative CORDIC datapath: drives the
// operand mux, register enable and shift index, then offers the result.
module cordic_seq_ctrl
  import cordic_pkg::*;
#(
  parameter int N_ITER = N_ITER_DEF,
  parameter int IDX_W  = $clog2(N_ITER)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             in_ready,
  output logic             mux_sel,
  output logic             reg_en,
  output logic [IDX_W-1:0] iter_idx,
  output logic             last_iter,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       fsm_state
);

  // Handshakes: a start is taken on a rising edge where start & in_ready;
  // a result is taken on a rising edge where out_valid & out_ready.

  state_t state;
  state_t state_n;
  logic   accept;
  logic   tc;

  // Only combinational input-to-output path: releasing DONE frees the slot.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = start && in_ready;
  assign last_iter = (state == ITER) && tc;
  assign fsm_state = state;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = LOAD;
      LOAD:    state_n = ITER;
      ITER:    if (tc) state_n = DONE;
      DONE:    if (out_ready) state_n = start ? LOAD : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mux_sel   <= SEL_INPUT;
      reg_en    <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      mux_sel   <= ((state_n == ITER) || (state_n == DONE)) ? SEL_FEEDBACK : SEL_INPUT;
      reg_en    <= (state_n == LOAD) || (state_n == ITER);
      busy      <= (state_n == LOAD) || (state_n == ITER);
      out_valid <= (state_n == DONE);
    end
  end

  // Cleared as LOAD is entered, so LOAD and the first ITER cycle both show 0.
  cordic_iter_counter #(
    .N_ITER(N_ITER),
    .IDX_W (IDX_W)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .enable(state == ITER),
    .count (iter_idx),
    .tc    (tc)
  );

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Directed bench for cordic_seq_ctrl: per-cycle expected output vectors are
// queued by the driver and compared by an independent negedge monitor.
module tb_cordic_seq_ctrl;

  localparam int N     = 16;
  localparam int IDX_W = 4;
  localparam int W     = 10;

  logic             clk;
  logic             rst;
  logic             start;
  logic             in_ready;
  logic             mux_sel;
  logic             reg_en;
  logic [IDX_W-1:0] iter_idx;
  logic             last_iter;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       fsm_state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks;
  int           failures;

  cordic_seq_ctrl #(.N_ITER(N), .IDX_W(IDX_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_ready (in_ready),
    .mux_sel  (mux_sel),
    .reg_en   (reg_en),
    .iter_idx (iter_idx),
    .last_iter(last_iter),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // vector layout: {in_ready, mux_sel, reg_en, iter_idx, last_iter, busy, out_valid}
  function automatic logic [W-1:0] ev(input logic ir, input logic mux, input logic en,
                                      input logic [IDX_W-1:0] idx, input logic last,
                                      input logic bsy, input logic vld);
    return {ir, mux, en, idx, last, bsy, vld};
  endfunction

  function automatic logic [W-1:0] s_idle(input int idx);
    return ev(1'b1, 1'b0, 1'b0, IDX_W'(idx), 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [W-1:0] s_load();
    return ev(1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b0);
  endfunction

  function automatic logic [W-1:0] s_iter(input int k);
    return ev(1'b0, 1'b1, 1'b1, IDX_W'(k), (k == N - 1), 1'b1, 1'b0);
  endfunction

  function automatic logic [W-1:0] s_done(input logic rdy);
    return ev(rdy, 1'b1, 1'b0, IDX_W'(N - 1), 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic logic [W-1:0] actual();
    return {in_ready, mux_sel, reg_en, iter_idx, last_iter, busy, out_valid};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (ir,mux,en,idx,last,busy,vld) t=%0t",
               name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      chk(n, actual(), e);
    end
  end

  // driver: apply inputs for one rising edge and queue the post-edge outputs
  task automatic step(input logic s, input logic r, input logic [W-1:0] e, input string n);
    start     = s;
    out_ready = r;
    @(posedge clk);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(negedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input int busy_start_at);
    step(1'b1, 1'b1, s_load(), {tag, "_load"});
    for (int k = 0; k < N; k++)
      step(k == busy_start_at, 1'b1, s_iter(k), $sformatf("%s_iter%0d", tag, k));
    step(1'b0, 1'b1, s_done(1'b1), {tag, "_done"});
    step(1'b0, 1'b1, s_idle(N - 1), {tag, "_idle"});
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    step(1'b0, 1'b1, s_idle(0), "reset_idle0");
    step(1'b1, 1'b0, s_load(), "reset_first_load");
    for (int k = 0; k < N; k++)
      step(1'b0, 1'b1, s_iter(k), $sformatf("first_iter%0d", k));
    step(1'b0, 1'b1, s_done(1'b1), "first_done");
    step(1'b0, 1'b1, s_idle(N - 1), "first_idle");

    run_op("single", -1);

    // backpressure: hold DONE five cycles with start pulses that must be ignored
    step(1'b1, 1'b1, s_load(), "bp_load");
    for (int k = 0; k < N; k++)
      step(1'b0, 1'b1, s_iter(k), $sformatf("bp_iter%0d", k));
    step(1'b0, 1'b0, s_done(1'b0), "bp_done_enter");
    for (int c = 0; c < 5; c++)
      step(c[0], 1'b0, s_done(1'b0), $sformatf("bp_hold%0d", c));
    step(1'b0, 1'b1, s_idle(N - 1), "bp_release_idle");
    step(1'b0, 1'b1, s_idle(N - 1), "bp_still_idle");

    // back-to-back: start held high, DONE goes straight to LOAD
    step(1'b1, 1'b1, s_load(), "b2b_load0");
    for (int k = 0; k < N; k++)
      step(1'b1, 1'b1, s_iter(k), $sformatf("b2b0_iter%0d", k));
    step(1'b1, 1'b1, s_done(1'b1), "b2b_done0");
    step(1'b1, 1'b1, s_load(), "b2b_load1");
    for (int k = 0; k < N; k++)
      step(1'b1, 1'b1, s_iter(k), $sformatf("b2b1_iter%0d", k));
    step(1'b0, 1'b1, s_done(1'b1), "b2b_done1");
    step(1'b0, 1'b1, s_idle(N - 1), "b2b_idle");

    // start pulsed while iter_idx=7 is showing must not disturb the sequence
    run_op("busy_start", 8);
    step(1'b0, 1'b1, s_idle(N - 1), "busy_start_no_second_op");

    // reset mid-operation, asserted between edges
    step(1'b1, 1'b1, s_load(), "midrst_load");
    for (int k = 0; k <= 9; k++)
      step(1'b0, 1'b1, s_iter(k), $sformatf("midrst_iter%0d", k));
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_clear", actual(), s_idle(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_held_idle", actual(), s_idle(0));
    step(1'b0, 1'b1, s_idle(0), "post_reset_idle");
    run_op("after_reset", -1);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
